wishbone_arbiter: RTL and testbench
===================================

# wishbone_arbiter

Round-robin arbiter sharing one classic Wishbone slave port (the 16×32 register block) among `NUM_MASTERS` requesters. Grants whole bus tenures keyed on `cyc`, muxes the owner's address/data/control to the slave and routes `ack` back. Guards against a slave that never acknowledges, for example a halted slave, with a per-access timeout that returns `err` to the owner. Sits between the master-side interconnect and the register-block slave.

## Interface
- `NUM_MASTERS`, 4, number of requesters (2..8)
- `ADDR_W`, 4, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 15, cycles of unacknowledged `s_stb` before error (1..255)

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `m_cyc`  in  NUM_MASTERS  per-master cycle request
- `m_stb`  in  NUM_MASTERS  per-master strobe
- `m_we`  in  NUM_MASTERS  per-master write enable
- `m_adr`  in  NUM_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W]
- `m_dat_mosi`  in  NUM_MASTERS*DATA_W  packed write data
- `m_dat_miso`  out  DATA_W  read data, broadcast to all masters
- `m_ack`  out  NUM_MASTERS  one-hot ack to owner
- `m_err`  out  NUM_MASTERS  one-hot timeout error to owner
- `s_cyc`, `s_stb`, `s_we`  out  1  to slave
- `s_adr`  out  ADDR_W  to slave
- `s_dat_mosi`  out  DATA_W  to slave
- `s_dat_miso`  in  DATA_W  from slave
- `s_ack`  in  1  from slave, registered one cycle after a sampled access
- `grant`  out  NUM_MASTERS  one-hot current owner (registered)
- `busy`  out  1  state != IDLE

## Operation
- **States:** IDLE, OWN, ERR, DRAIN.
- **IDLE:**
  - If any `m_cyc` is set, pick the first requester scanning from `last+1` modulo `NUM_MASTERS`.
  - Register `grant` and `owner`, then go to OWN.
  - With no request, stay in IDLE.
- **OWN:**
  - `s_cyc = m_cyc[owner]`, `s_we`/`s_adr`/`s_dat_mosi` from owner.
  - `s_stb = m_stb[owner] & ~s_ack`. Masking during the ack cycle prevents the slave from sampling a duplicate access.
  - `m_ack[owner] = s_ack`; `m_dat_miso = s_dat_miso` at all times.
- **Owner drops `m_cyc`:** `last <= owner`, `grant <= 0`, go to IDLE. Always one idle cycle between tenures; no back-to-back re-grant.
- **Timeout counter** (width clog2(TIMEOUT+1)):
  - Increments each OWN cycle with `s_stb` high and `s_ack` low.
  - Clears on `s_ack`, on `s_stb` low and on leaving OWN.
  - When the count reaches `TIMEOUT`, go to ERR.
- **ERR (1 cycle):**
  - `m_err[owner] = 1`.
  - `s_cyc` and `s_stb` are forced to 0.
  - Then go to DRAIN.
- **DRAIN:**
  - `s_cyc` and `s_stb` stay 0; `grant` is held.
  - When `m_cyc[owner]` is 0, set `last <= owner` and go to IDLE.
- **Late ack:** an `s_ack` arriving in ERR or DRAIN is not forwarded.
- **Non-owners:** `m_ack` and `m_err` to non-owners are always 0. Non-owner `stb` and `cyc` are ignored.

## Timing
- **Reset values:**
  - state IDLE, `grant` 0, `last` = NUM_MASTERS-1 (master 0 wins first).
  - Counter 0; `busy` 0.
  - All `s_*` outputs, `m_ack` and `m_err` are 0.
- **Latency:**
  - Request at cycle 0 in IDLE → `grant` and `s_cyc`/`s_stb` at cycle 1.
  - Slave ack and `m_ack` at cycle 2.
  - Each subsequent held-`stb` access takes 2 cycles because of the ack masking.
- **Routing:** `m_ack`/`m_dat_miso` are combinational from `s_ack`/`s_dat_miso`. All other slave outputs are combinational from registered `owner` plus master inputs.
- **Simultaneous requests** in IDLE: the round-robin pick decides. A new request arriving while an owner holds the bus waits.
- **Drop and request together:** owner dropping `cyc` in the same cycle another master requests → IDLE next cycle, new grant the cycle after.
- **Timeout timing:** `m_err` is asserted in cycle T+1, where cycle 1 is the first unacknowledged `s_stb` cycle and T = `TIMEOUT`.
- **`rst` mid-tenure:** outputs return to reset values on the next edge. No ack or err is issued for the aborted access.

## Structure
- **Package `wb_arb_pkg`:**
  - State enum (`IDLE`, `OWN`, `ERR`, `DRAIN`).
  - Function returning clog2-based index width.
  - Constant for maximum `NUM_MASTERS`.
- **Sub-module `wb_rr_picker`:** combinational; takes `req[N]` and `last` index, returns one-hot grant, index and valid. Reusable elsewhere.

## Test plan
- **Single write then read:** master 2 writes `0xDEADBEEF` to addr 5, drops `cyc`, then reads addr 5.
  - `grant` = `0100`, `m_ack[2]` at cycle 2 of each access.
  - `m_dat_miso` = `0xDEADBEEF`.
- **Fairness:** all 4 masters hold `cyc` and do one access each → tenure order 0,1,2,3,0 with one idle cycle between tenures.
- **Timeout:** slave halted (`dat_mosi` `0xCAFEBABE` written first) and master 1 strobes.
  - `m_err[1]` pulses after 15 unacknowledged cycles; `s_cyc` 0 during ERR/DRAIN.
  - `grant` released after master 1 drops `cyc`.
- **Ack masking:** master 0 holds `stb` for 4 accesses to the same address → exactly 4 slave acks, 8 cycles, no duplicate writes.
- **Reset mid-tenure:** master 3 owns the bus, `rst` is pulsed → next cycle `grant` 0, `s_cyc` 0, `last` = 3 (NUM_MASTERS-1), master 0 wins a subsequent 0/3 contention.
- **Ignored non-owner:** master 1 strobes while master 0 owns the bus → no `m_ack[1]` and no slave write from master 1.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    ERR,
    DRAIN
  } arb_state_e;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan last+1, last+2, ... modulo N and keep the first requester found.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    grant    = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid           = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone slave among several masters,
// with a per-access timeout that answers a silent slave with err.
module wishbone_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_cyc,
  input  logic [NUM_MASTERS-1:0]        m_stb,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_mosi,
  output logic [DATA_W-1:0]             m_dat_miso,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_adr,
  output logic [DATA_W-1:0]             s_dat_mosi,
  input  logic [DATA_W-1:0]             s_dat_miso,
  input  logic                          s_ack,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          busy
);

  localparam int IDX_W = idx_width(NUM_MASTERS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e state, next_state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       last;
  logic [CNT_W-1:0]       count;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   own_we;
  logic [ADDR_W-1:0]      own_adr;
  logic [DATA_W-1:0]      own_dat;
  logic                   stall;
  logic                   timeout_hit;

  wb_rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (m_cyc),
    .last  (last),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign own_cyc = m_cyc[owner];
  assign own_stb = m_stb[owner];
  assign own_we  = m_we[owner];
  assign own_adr = m_adr[int'(owner)*ADDR_W +: ADDR_W];
  assign own_dat = m_dat_mosi[int'(owner)*DATA_W +: DATA_W];

  // A stalled cycle is one where the slave sees a strobe it has not yet answered.
  assign stall       = (state == OWN) && s_stb && !s_ack;
  assign timeout_hit = stall && (count == CNT_LAST);

  assign m_dat_miso = s_dat_miso;
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state: tenures end when the owner drops cyc; a silent slave diverts to ERR.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (pick_valid) next_state = OWN;
      OWN: begin
        if (!own_cyc)         next_state = IDLE;
        else if (timeout_hit) next_state = ERR;
      end
      ERR:   next_state = DRAIN;
      DRAIN: if (!own_cyc) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: only the owner reaches the slave, and only while it really owns the bus.
  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_adr      = '0;
    s_dat_mosi = '0;
    m_ack      = '0;
    m_err      = '0;
    case (state)
      OWN: begin
        s_cyc        = own_cyc;
        s_stb        = own_stb & ~s_ack;
        s_we         = own_we;
        s_adr        = own_adr;
        s_dat_mosi   = own_dat;
        m_ack[owner] = s_ack;
      end
      ERR:     m_err[owner] = 1'b1;
      default: ;
    endcase
  end

  // Ownership bookkeeping: grant/owner on entry, last on release, stall counter in OWN.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      owner <= '0;
      last  <= LAST_RST;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (pick_valid) begin
            grant <= pick_grant;
            owner <= pick_idx;
          end
        end
        OWN: begin
          if (!own_cyc) begin
            last  <= owner;
            grant <= '0;
            count <= '0;
          end else if (timeout_hit || !stall) begin
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        ERR: count <= '0;
        DRAIN: begin
          count <= '0;
          if (!own_cyc) begin
            last  <= owner;
            grant <= '0;
          end
        end
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed and randomized bench for wishbone_arbiter with a 16x32 register-block slave.
module tb_wishbone_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   m_cyc;
  logic [3:0]   m_stb;
  logic [3:0]   m_we;
  logic [15:0]  m_adr;
  logic [127:0] m_dat_mosi;
  logic [31:0]  m_dat_miso;
  logic [3:0]   m_ack;
  logic [3:0]   m_err;
  logic         s_cyc;
  logic         s_stb;
  logic         s_we;
  logic [3:0]   s_adr;
  logic [31:0]  s_dat_mosi;
  logic [31:0]  s_dat_miso;
  logic         s_ack;
  logic [3:0]   grant;
  logic         busy;

  logic         tb_init;
  logic         slave_halt;
  int           slave_samples;
  logic [31:0]  slave_mem [16];

  logic [31:0]  model_mem [16];
  int           model_last;
  int           checks;
  int           failures;

  wishbone_arbiter #(
    .NUM_MASTERS (4),
    .ADDR_W      (4),
    .DATA_W      (32),
    .TIMEOUT     (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_cyc      (m_cyc),
    .m_stb      (m_stb),
    .m_we       (m_we),
    .m_adr      (m_adr),
    .m_dat_mosi (m_dat_mosi),
    .m_dat_miso (m_dat_miso),
    .m_ack      (m_ack),
    .m_err      (m_err),
    .s_cyc      (s_cyc),
    .s_stb      (s_stb),
    .s_we       (s_we),
    .s_adr      (s_adr),
    .s_dat_mosi (s_dat_mosi),
    .s_dat_miso (s_dat_miso),
    .s_ack      (s_ack),
    .grant      (grant),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-block slave: acks one cycle after each sampled access unless halted.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 16; i++) slave_mem[i] <= '0;
      s_ack         <= 1'b0;
      s_dat_miso    <= '0;
      slave_samples <= 0;
    end else if (s_cyc && s_stb && !slave_halt) begin
      s_ack         <= 1'b1;
      slave_samples <= slave_samples + 1;
      s_dat_miso    <= slave_mem[s_adr];
      if (s_we) slave_mem[s_adr] <= s_dat_mosi;
    end else begin
      s_ack <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first requester after 'last', modulo four.
  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic set_master(input int m, input logic stb, input logic we,
                            input logic [3:0] adr, input logic [31:0] dat);
    m_stb[m]             = stb;
    m_we[m]              = we;
    m_adr[m*4 +: 4]      = adr;
    m_dat_mosi[m*32 +: 32] = dat;
  endtask

  // One access by master m (already owner or about to be); checks latency, routing and data.
  task automatic run_access(input int m, input logic we, input logic [3:0] adr,
                            input logic [31:0] dat, input int exp_lat,
                            output logic [31:0] rdat);
    int  lat;
    logic got;
    lat = 0;
    got = 1'b0;
    set_master(m, 1'b1, we, adr, dat);
    while (!got && lat < 40) begin
      tick();
      lat++;
      check("nonowner_ack", 32'(m_ack & ~(4'b1 << m)), 32'd0);
      if (m_ack !== 4'b0) got = 1'b1;
    end
    check("access_latency", 32'(lat), 32'(exp_lat));
    check("ack_onehot", 32'(m_ack), 32'(4'b1 << m));
    rdat = m_dat_miso;
    if (we) model_mem[adr] = dat;
    else    check("read_data", m_dat_miso, model_mem[adr]);
    set_master(m, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  // Full tenure from the idle cycle in which m's cyc is already raised.
  task automatic serve(input int m, input int nacc);
    logic [31:0] rd;
    tick();
    check("tenure_grant", 32'(grant), 32'(4'b1 << m));
    check("tenure_busy", 32'(busy), 32'd1);
    for (int i = 0; i < nacc; i++) begin
      run_access(m, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 (i == 0) ? 1 : 2, rd);
    end
    m_cyc[m] = 1'b0;
    tick();
    check("idle_gap_grant", 32'(grant), 32'd0);
    check("idle_gap_busy", 32'(busy), 32'd0);
    model_last = m;
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  pending;
    int          acks;
    int          cnt;
    int          base;
    int          nxt;
    int          order [5];

    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    tb_init    = 1'b1;
    slave_halt = 1'b0;
    m_cyc      = '0;
    m_stb      = '0;
    m_we       = '0;
    m_adr      = '0;
    m_dat_mosi = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    model_last = 3;

    // Reset state
    repeat (3) tick();
    tb_init = 1'b0;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_cyc", 32'(s_cyc), 32'd0);
    check("rst_s_stb", 32'(s_stb), 32'd0);
    check("rst_s_adr", 32'(s_adr), 32'd0);
    check("rst_s_dat", s_dat_mosi, 32'd0);
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    rst = 1'b0;
    tick();

    // Single write then read by master 2
    m_cyc[2] = 1'b1;
    set_master(2, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF);
    tick();
    check("wr_grant_c1", 32'(grant), 32'h4);
    check("wr_s_cyc_c1", 32'(s_cyc), 32'd1);
    check("wr_s_stb_c1", 32'(s_stb), 32'd1);
    check("wr_s_we_c1", 32'(s_we), 32'd1);
    check("wr_s_adr_c1", 32'(s_adr), 32'd5);
    check("wr_s_dat_c1", s_dat_mosi, 32'hDEADBEEF);
    check("wr_m_ack_c1", 32'(m_ack), 32'd0);
    tick();
    check("wr_m_ack_c2", 32'(m_ack), 32'h4);
    check("wr_stb_masked", 32'(s_stb), 32'd0);
    model_mem[5] = 32'hDEADBEEF;
    set_master(2, 1'b0, 1'b0, 4'd0, 32'd0);
    m_cyc[2] = 1'b0;
    tick();
    check("wr_release", 32'(grant), 32'd0);
    model_last = 2;
    m_cyc[2] = 1'b1;
    run_access(2, 1'b0, 4'd5, 32'd0, 2, rd);
    check("rd_deadbeef", rd, 32'hDEADBEEF);
    m_cyc[2] = 1'b0;
    tick();
    model_last = 2;

    // Ack masking: master 0 holds stb for four writes to one address
    base = slave_samples;
    acks = 0;
    m_cyc[0] = 1'b1;
    set_master(0, 1'b1, 1'b1, 4'd10, 32'h1000_0000);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (m_ack[0]) begin
        check("mask_ack_even_cycle", 32'(c % 2), 32'd0);
        acks++;
        m_dat_mosi[31:0] = 32'h1000_0000 + 32'(acks);
      end
    end
    check("mask_ack_count", 32'(acks), 32'd4);
    set_master(0, 1'b0, 1'b0, 4'd0, 32'd0);
    check("mask_slave_samples", 32'(slave_samples - base), 32'd4);
    model_mem[10] = 32'h1000_0003;
    m_cyc[0] = 1'b0;
    tick();
    model_last = 0;
    m_cyc[0] = 1'b1;
    serve(0, 0);
    m_cyc[0] = 1'b1;
    tick();
    check("mask_rd_grant", 32'(grant), 32'h1);
    run_access(0, 1'b0, 4'd10, 32'd0, 1, rd);
    check("mask_final_value", rd, 32'h1000_0003);
    m_cyc[0] = 1'b0;
    tick();
    model_last = 0;

    // Non-owner master 1 strobes while master 0 owns the bus
    m_cyc[0] = 1'b1;
    tick();
    check("nonown_grant", 32'(grant), 32'h1);
    m_cyc[1] = 1'b1;
    set_master(1, 1'b1, 1'b1, 4'd7, 32'h1111_1111);
    run_access(0, 1'b0, 4'd9, 32'd0, 1, rd);
    m_cyc[1] = 1'b0;
    set_master(1, 1'b0, 1'b0, 4'd0, 32'd0);
    check("nonown_no_write", slave_mem[7], model_mem[7]);
    m_cyc[0] = 1'b0;
    tick();
    model_last = 0;

    // Timeout: write CAFEBABE, then halt the slave and strobe from master 1
    m_cyc[1] = 1'b1;
    run_access(1, 1'b1, 4'd3, 32'hCAFEBABE, 2, rd);
    m_cyc[1] = 1'b0;
    tick();
    model_last = 1;
    slave_halt = 1'b1;
    m_cyc[1] = 1'b1;
    set_master(1, 1'b1, 1'b1, 4'd3, 32'h1234_5678);
    cnt = 0;
    while (m_err === 4'b0 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("to_err_cycle", 32'(cnt), 32'd16);
    check("to_err_onehot", 32'(m_err), 32'h2);
    check("to_err_s_cyc", 32'(s_cyc), 32'd0);
    check("to_err_s_stb", 32'(s_stb), 32'd0);
    check("to_err_ack", 32'(m_ack), 32'd0);
    set_master(1, 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    check("drain_err_clear", 32'(m_err), 32'd0);
    check("drain_s_cyc", 32'(s_cyc), 32'd0);
    check("drain_grant_held", 32'(grant), 32'h2);
    check("drain_busy", 32'(busy), 32'd1);
    slave_halt = 1'b0;
    tick();
    check("drain_grant_held2", 32'(grant), 32'h2);
    m_cyc[1] = 1'b0;
    tick();
    check("drain_release", 32'(grant), 32'd0);
    check("drain_release_busy", 32'(busy), 32'd0);
    model_last = 1;
    m_cyc[1] = 1'b1;
    run_access(1, 1'b0, 4'd3, 32'd0, 2, rd);
    check("to_cafebabe_kept", rd, 32'hCAFEBABE);
    m_cyc[1] = 1'b0;
    tick();
    model_last = 1;

    // Reset in the middle of a tenure by master 3
    m_cyc[3] = 1'b1;
    tick();
    check("rstmid_grant3", 32'(grant), 32'h8);
    set_master(3, 1'b1, 1'b0, 4'd0, 32'd0);
    rst = 1'b1;
    tick();
    check("rstmid_grant", 32'(grant), 32'd0);
    check("rstmid_s_cyc", 32'(s_cyc), 32'd0);
    check("rstmid_m_ack", 32'(m_ack), 32'd0);
    check("rstmid_m_err", 32'(m_err), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    set_master(3, 1'b0, 1'b0, 4'd0, 32'd0);
    m_cyc[0] = 1'b1;
    tick();
    check("rstmid_m0_wins", 32'(grant), 32'h1);
    m_cyc = '0;
    tick();
    model_last = 0;

    // Fairness after a fresh reset: all four hold cyc, master 0 re-requests
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last = 3;
    order = '{0, 1, 2, 3, 0};
    m_cyc = 4'hF;
    for (int t = 0; t < 5; t++) begin
      nxt = rr_pick(m_cyc, model_last);
      check("fair_model_order", 32'(nxt), 32'(order[t]));
      serve(order[t], 1);
      if (t == 0) m_cyc[0] = 1'b1;
    end

    // Randomized request sets checked against the round-robin model
    for (int r = 0; r < 25; r++) begin
      pending = 4'($urandom_range(1, 15));
      m_cyc   = pending;
      while (pending != 4'b0) begin
        nxt = rr_pick(pending, model_last);
        serve(nxt, $urandom_range(1, 3));
        pending[nxt] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
